// File: rtl/inc_counter.sv
// inc_counter: registered up/down counter bounded to [0, limit].
// Steps by STEP per enabled cycle, wraps or saturates at the bounds,
// and pulses wrap for one cycle after any out-of-range step attempt.
module inc_counter #(
  parameter int unsigned       WIDTH       = 16,
  parameter int unsigned       STEP        = 1,
  parameter int unsigned       SATURATE    = 0,
  parameter logic [WIDTH-1:0]  RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             dec,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] out,
  output logic             wrap,
  output logic             at_limit
);

  // One extra bit so out+STEP never silently folds at 2^WIDTH.
  localparam logic [WIDTH:0] STEP_W = (WIDTH+1)'(STEP);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             wrap_q, wrap_d;

  logic [WIDTH:0]   cnt_w, lim_w, sum_w, diff_w;
  logic             up_ok, dn_ok;

  // Widened step arithmetic and in-range tests for both directions.
  always_comb begin
    cnt_w  = {1'b0, cnt_q};
    lim_w  = {1'b0, limit};
    sum_w  = cnt_w + STEP_W;
    diff_w = cnt_w - STEP_W;
    // An out-of-range count already exceeds limit, so sum fails too.
    up_ok  = (sum_w <= lim_w);
    // Underflow check first; diff is only meaningful when cnt >= STEP.
    dn_ok  = (cnt_w >= STEP_W) && (diff_w <= lim_w);
  end

  // Next-state selection: load > step > hold; every branch sets both regs.
  always_comb begin
    cnt_d  = cnt_q;
    wrap_d = 1'b0;
    if (load) begin
      cnt_d  = load_value;
      wrap_d = 1'b0;
    end else if (en) begin
      if (!dec) begin
        if (up_ok) begin
          cnt_d  = sum_w[WIDTH-1:0];
          wrap_d = 1'b0;
        end else begin
          // Wrap restarts at 0 with no remainder carried over.
          cnt_d  = (SATURATE != 0) ? limit : '0;
          wrap_d = 1'b1;
        end
      end else begin
        if (dn_ok) begin
          cnt_d  = diff_w[WIDTH-1:0];
          wrap_d = 1'b0;
        end else begin
          cnt_d  = (SATURATE != 0) ? '0 : limit;
          wrap_d = 1'b1;
        end
      end
    end
  end

  // Count and wrap registers; reset discards any simultaneous load/en.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= RESET_VALUE;
      wrap_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      wrap_q <= wrap_d;
    end
  end

  assign out      = cnt_q;
  assign wrap     = wrap_q;
  assign at_limit = (cnt_q == limit);

endmodule

// File: tb/tb_inc_counter.sv
// tb_inc_counter: three counter configurations share one stimulus stream
// and are compared every cycle against an arithmetic reference model.
module tb_inc_counter;

  logic        clk = 1'b0;
  logic        reset, en, dec, load;
  logic [15:0] load_value, limit;

  logic [15:0] out_a, out_b, out_c;
  logic        wrap_a, wrap_b, wrap_c;
  logic        atl_a, atl_b, atl_c;

  int vectors = 0;
  int miscompares = 0;

  // Model state per configuration: a = step1 wrap, b = step3 wrap,
  // c = step4 saturate with reset value 5.
  int m_out [3];
  int m_wrap[3];
  int STEPS [3] = '{1, 3, 4};
  int SATS  [3] = '{0, 0, 1};
  int RVS   [3] = '{0, 0, 5};

  always #5 clk = ~clk;

  inc_counter #(.WIDTH(16), .STEP(1), .SATURATE(0), .RESET_VALUE(16'd0)) u_a (
    .clk(clk), .reset(reset), .en(en), .dec(dec), .load(load),
    .load_value(load_value), .limit(limit),
    .out(out_a), .wrap(wrap_a), .at_limit(atl_a));

  inc_counter #(.WIDTH(16), .STEP(3), .SATURATE(0), .RESET_VALUE(16'd0)) u_b (
    .clk(clk), .reset(reset), .en(en), .dec(dec), .load(load),
    .load_value(load_value), .limit(limit),
    .out(out_b), .wrap(wrap_b), .at_limit(atl_b));

  inc_counter #(.WIDTH(16), .STEP(4), .SATURATE(1), .RESET_VALUE(16'd5)) u_c (
    .clk(clk), .reset(reset), .en(en), .dec(dec), .load(load),
    .load_value(load_value), .limit(limit),
    .out(out_c), .wrap(wrap_c), .at_limit(atl_c));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: the bounded range rules written as plain integer math.
  function automatic void model_edge();
    for (int k = 0; k < 3; k++) begin
      int cur, st, lim;
      cur = m_out[k]; st = STEPS[k]; lim = int'(limit);
      if (reset) begin
        m_out[k] = RVS[k]; m_wrap[k] = 0;
      end else if (load) begin
        m_out[k] = int'(load_value); m_wrap[k] = 0;
      end else if (en && !dec) begin
        if (cur + st <= lim) begin m_out[k] = cur + st; m_wrap[k] = 0; end
        else begin m_out[k] = SATS[k] ? lim : 0; m_wrap[k] = 1; end
      end else if (en && dec) begin
        if (cur >= st && cur - st <= lim) begin m_out[k] = cur - st; m_wrap[k] = 0; end
        else begin m_out[k] = SATS[k] ? 0 : lim; m_wrap[k] = 1; end
      end else begin
        m_wrap[k] = 0;
      end
    end
  endfunction

  task automatic check_all(input string tag);
    chk({tag, ".a.out"},  32'(out_a),  32'(m_out[0]));
    chk({tag, ".a.wrap"}, 32'(wrap_a), 32'(m_wrap[0]));
    chk({tag, ".a.atl"},  32'(atl_a),  32'(m_out[0] == int'(limit)));
    chk({tag, ".b.out"},  32'(out_b),  32'(m_out[1]));
    chk({tag, ".b.wrap"}, 32'(wrap_b), 32'(m_wrap[1]));
    chk({tag, ".b.atl"},  32'(atl_b),  32'(m_out[1] == int'(limit)));
    chk({tag, ".c.out"},  32'(out_c),  32'(m_out[2]));
    chk({tag, ".c.wrap"}, 32'(wrap_c), 32'(m_wrap[2]));
    chk({tag, ".c.atl"},  32'(atl_c),  32'(m_out[2] == int'(limit)));
  endtask

  // Apply one cycle of inputs, advance the model at the edge, check after.
  task automatic cyc(input string tag, input logic r, input logic l, input logic e,
                     input logic d, input logic [15:0] lv, input logic [15:0] lim);
    reset = r; load = l; en = e; dec = d; load_value = lv; limit = lim;
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  initial begin
    reset = 1'b1; load = 1'b0; en = 1'b0; dec = 1'b0;
    load_value = '0; limit = 16'hFFFF;
    for (int k = 0; k < 3; k++) begin m_out[k] = 0; m_wrap[k] = 0; end

    // Reset state
    cyc("rst", 1, 0, 0, 0, 16'h0, 16'hFFFF);
    chk("rst.a.const", 32'(out_a), 32'd0);
    chk("rst.c.const", 32'(out_c), 32'd5);

    // Plain 16-bit increment and modular rollover
    for (int i = 0; i < 3; i++) cyc("inc", 0, 0, 1, 0, 16'h0, 16'hFFFF);
    chk("inc.a.three", 32'(out_a), 32'd3);
    cyc("ld_fffe", 0, 1, 0, 0, 16'hFFFE, 16'hFFFF);
    cyc("to_ffff", 0, 0, 1, 0, 16'h0, 16'hFFFF);
    chk("to_ffff.a.wrap", 32'(wrap_a), 32'd0);
    cyc("roll", 0, 0, 1, 0, 16'h0, 16'hFFFF);
    chk("roll.a.out", 32'(out_a), 32'd0);
    chk("roll.a.wrap", 32'(wrap_a), 32'd1);
    cyc("roll_hold", 0, 0, 0, 0, 16'h0, 16'hFFFF);

    // Small range, stride 3 wraps to 0; down wraps to limit
    cyc("ld0_l10", 0, 1, 0, 0, 16'h0, 16'd10);
    for (int i = 0; i < 4; i++) cyc("up_l10", 0, 0, 1, 0, 16'h0, 16'd10);
    chk("up_l10.b.out", 32'(out_b), 32'd0);
    chk("up_l10.c.out", 32'(out_c), 32'd10);
    cyc("dn_l10", 0, 0, 1, 1, 16'h0, 16'd10);
    chk("dn_l10.b.out", 32'(out_b), 32'd10);

    // Saturation at both ends
    cyc("ld0_sat", 0, 1, 0, 0, 16'h0, 16'd10);
    for (int i = 0; i < 4; i++) cyc("sat_up", 0, 0, 1, 0, 16'h0, 16'd10);
    chk("sat_up.c.wrap", 32'(wrap_c), 32'd1);
    for (int i = 0; i < 4; i++) cyc("sat_dn", 0, 0, 1, 1, 16'h0, 16'd10);
    chk("sat_dn.c.out", 32'(out_c), 32'd0);
    chk("sat_dn.c.wrap", 32'(wrap_c), 32'd1);

    // Priority: reset beats load/en, load beats en
    cyc("prio_rst", 1, 1, 1, 0, 16'h1234, 16'hFFFF);
    cyc("prio_ld", 0, 1, 1, 0, 16'h1234, 16'hFFFF);
    chk("prio_ld.a.out", 32'(out_a), 32'h1234);

    // Out-of-range load then step; empty range
    cyc("ld9", 0, 1, 0, 0, 16'd9, 16'd5);
    cyc("oor_up", 0, 0, 1, 0, 16'h0, 16'd5);
    cyc("ld9b", 0, 1, 0, 0, 16'd9, 16'd5);
    cyc("oor_dn", 0, 0, 1, 1, 16'h0, 16'd5);
    cyc("ld0_lim0", 0, 1, 0, 0, 16'h0, 16'd0);
    for (int i = 0; i < 3; i++) cyc("lim0", 0, 0, 1, i[0], 16'h0, 16'd0);

    // Count to limit and hold
    cyc("ld0_l7", 0, 1, 0, 0, 16'h0, 16'd7);
    for (int i = 0; i < 7; i++) cyc("to7", 0, 0, 1, 0, 16'h0, 16'd7);
    chk("to7.a.atl", 32'(atl_a), 32'd1);
    for (int i = 0; i < 4; i++) cyc("hold7", 0, 0, 0, 0, 16'h0, 16'd7);

    // Randomized traffic biased toward small ranges to hit the bounds
    for (int i = 0; i < 400; i++) begin
      logic        r, l, e, d;
      logic [15:0] lv, lim;
      r   = ($urandom_range(0, 49) == 0);
      l   = ($urandom_range(0, 9) == 0);
      e   = ($urandom_range(0, 3) != 0);
      d   = $urandom_range(0, 1) == 1;
      lim = ($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'($urandom_range(0, 24));
      lv  = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 30));
      cyc("rand", r, l, e, d, lv, lim);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/inc_counter.md
Name: inc_counter

Overview:
Parametrised, registered successor to the combinational 16-bit incrementer. It holds a WIDTH-bit count that steps up or down by STEP per enabled cycle and can be loaded directly. The count is bounded to a programmable range [0, limit] and the block either wraps or saturates at the bounds. It serves as the building block for the Hack program counter and for general timers and address generators.

Parameters:
WIDTH, 16, count/data width in bits (>=2)
STEP, 1, increment/decrement magnitude (1 .. 2^WIDTH-1)
SATURATE, 0, 0 = wrap at bounds, 1 = clamp at bounds
RESET_VALUE, 0, count value after reset (WIDTH bits)

Ports:
clk  input  1  single rising-edge clock
reset  input  1  synchronous, active-high reset
en  input  1  step enable; count moves by STEP this cycle
dec  input  1  step direction when en=1: 0 = up, 1 = down
load  input  1  load load_value this cycle
load_value  input  WIDTH  value written on load
limit  input  WIDTH  inclusive upper bound of the count range
out  output  WIDTH  registered count
wrap  output  1  registered one-cycle pulse; a bound was crossed on the previous step
at_limit  output  1  combinational (out == limit)

Behaviour:
- Interface decision: one clock; reset is synchronous and active-high. All state updates occur on the rising edge of clk.
- Reset values: out=RESET_VALUE, wrap=0. at_limit follows out. Reset mid-count takes effect on the next edge and discards any simultaneous load or en.
- Priority per edge: reset > load > en > hold.
- On load: out=load_value; wrap=0. The value is taken verbatim even if load_value > limit.
- On hold (en=0, load=0): out unchanged; wrap=0.
- Step arithmetic is done in WIDTH+1 bits so there is no silent 2^WIDTH overflow.
- Up step (en=1, dec=0):
  - sum = out + STEP.
  - If sum <= limit: out=sum, wrap=0.
  - Else: wrap=1. If SATURATE=0, out=0 (restart, no remainder carry). If SATURATE=1, out=limit.
- Down step (en=1, dec=1):
  - If out >= STEP and (out - STEP) <= limit: out=out-STEP, wrap=0.
  - Else: wrap=1. If SATURATE=0, out=limit. If SATURATE=1, out=0.
- Out-of-range count: if out > limit (only reachable via load or reset), an up step always takes the "else" branch. For a down step, the result is compared against limit as stated above.
- Saturated hold: in saturate mode, repeated steps at a bound hold out and keep re-asserting wrap=1 on every enabled cycle.
- limit=0: out stays 0; every enabled step produces wrap=1 in either mode.
- limit = 2^WIDTH-1 with STEP=1 and SATURATE=0: behaves as a plain WIDTH-bit modular incrementer (0xFFFF+1 -> 0x0000, wrap=1).
- Latency: out and wrap change exactly one edge after the qualifying inputs. at_limit has zero latency from out.
- Inputs are not sampled while reset=1. There are no X-propagation dependencies; every branch assigns both registers.

Test Plan:
1. WIDTH=16, STEP=1, SATURATE=0, limit=0xFFFF; reset, then en=1 for 3 cycles -> out 0,1,2,3, wrap=0. Load 0xFFFE, 2 steps -> out 0xFFFF then 0x0000; wrap=1 only in the cycle after the 0xFFFF->0 step.
2. STEP=3, SATURATE=0, limit=10; steps from 0 -> 3,6,9,0 with wrap pulse on 0. Then dec=1 one step -> out=10, wrap=1.
3. SATURATE=1, limit=10, STEP=4; steps from 0 -> 4,8,10,10 with wrap=1 on both 10s. dec steps -> 6,2,0,0 with wrap=1 on both 0s.
4. Priority: reset=1 with load=1, en=1, load_value=0x1234 -> out=RESET_VALUE, wrap=0. Next cycle load=1, en=1 -> out=0x1234, no step applied, wrap=0.
5. Out-of-range and limit=0: limit=5, load 9, up step -> out=0 (wrap mode) with wrap=1. limit=0, en held 3 cycles -> out=0, wrap=1 on each, at_limit=1 throughout.
6. Hold and at_limit: limit=7, count to 7 -> at_limit=1 in the same cycle out=7. Drop en for 4 cycles -> out stays 7, wrap=0, at_limit stays 1.
